ack_tracker: RTL and testbench

ACK_TRACKER -- requirements
Module: ack_tracker

---
 rtl/ack_tracker.sv | 196 +++++++++++++++++++
 tb/tb_ack_tracker.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ack_tracker.sv
// ack_tracker: keeps per-ID outstanding read/write bitmaps, retires them on
// acknowledges, flags protocol errors (duplicate issue, unexpected ack) and,
// optionally, runs a no-progress watchdog.
//
// Optional feature: define ACK_TRACKER_WATCHDOG_EN to build the watchdog
// counter and the TIMEOUT state. Without it tmo_o is tied low and TIMEOUT is
// unreachable.
//
// Handshake: an issue is accepted on a rising clk_i edge when
// req_i & req_rdy_o & ce_i; req_rdy_o is combinational from registered state
// only. The ack side has no back-pressure: every cycle with ce_i high and
// ack_i == ~ACK_LEVEL is one acknowledge.
module ack_tracker #(
  parameter int   MAX_OUT   = 8,
  parameter int   TIMEOUT   = 1023,
  parameter logic ACK_LEVEL = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       req_i,
  input  logic       req_we_i,
  input  logic [3:0] req_id_i,
  input  logic       ack_i,
  input  logic       ack_we_i,
  input  logic [3:0] ack_rid_i,
  input  logic [3:0] ack_wid_i,
  input  logic       clr_i,
  output logic       req_rdy_o,
  output logic       busy_o,
  output logic       rd_done_o,
  output logic       wr_done_o,
  output logic [3:0] done_id_o,
  output logic       err_o,
  output logic [1:0] err_code_o,
  output logic       tmo_o,
  output logic [4:0] count_o,
  output logic [1:0] state_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_TIMEOUT = 2'd2
  } state_t;

  localparam logic [4:0] MAX_CNT = 5'(MAX_OUT);

  state_t      state_q, state_nxt;
  logic [15:0] rd_pend_q, rd_pend_nxt;
  logic [15:0] wr_pend_q, wr_pend_nxt;
  logic [4:0]  count_q, count_nxt;
  logic        err_q, err_nxt;
  logic [1:0]  err_code_q, err_code_nxt;
  logic        rd_done_q, rd_done_nxt;
  logic        wr_done_q, wr_done_nxt;
  logic [3:0]  done_id_q, done_id_nxt;
  logic        tmo_q;
  logic        wd_fire;

  logic        ack_vld, ack_pend, ack_hit, ack_bad;
  logic [3:0]  ack_id;
  logic [15:0] ack_oh, req_oh;
  logic [15:0] rd_after_ack, wr_after_ack;
  logic        iss_try, iss_pend, iss_ok, iss_dup;

  assign req_rdy_o  = (count_q < MAX_CNT) & ~tmo_q & ~err_q;
  assign busy_o     = (count_q != 5'd0);
  assign rd_done_o  = rd_done_q;
  assign wr_done_o  = wr_done_q;
  assign done_id_o  = done_id_q;
  assign err_o      = err_q;
  assign err_code_o = err_code_q;
  assign tmo_o      = tmo_q;
  assign count_o    = count_q;
  assign state_o    = state_q;

  // Decode the acknowledge and retire it before looking at the issue, so a
  // same-ID re-issue in the same cycle sees the bit already cleared.
  always_comb begin
    ack_vld      = (ack_i == ~ACK_LEVEL);
    ack_id       = ack_we_i ? ack_wid_i : ack_rid_i;
    ack_oh       = 16'd1 << ack_id;
    req_oh       = 16'd1 << req_id_i;
    ack_pend     = ack_we_i ? wr_pend_q[ack_id] : rd_pend_q[ack_id];
    ack_hit      = ack_vld & ack_pend;
    ack_bad      = ack_vld & ~ack_pend;
    rd_after_ack = rd_pend_q & ~((ack_hit & ~ack_we_i) ? ack_oh : 16'd0);
    wr_after_ack = wr_pend_q & ~((ack_hit &  ack_we_i) ? ack_oh : 16'd0);
    iss_try      = req_i & req_rdy_o;
    iss_pend     = req_we_i ? wr_after_ack[req_id_i] : rd_after_ack[req_id_i];
    iss_ok       = iss_try & ~iss_pend;
    iss_dup      = iss_try & iss_pend;
  end

  // Next values of the tracking datapath; clr_i overrides everything.
  always_comb begin
    rd_pend_nxt  = rd_after_ack | ((iss_ok & ~req_we_i) ? req_oh : 16'd0);
    wr_pend_nxt  = wr_after_ack | ((iss_ok &  req_we_i) ? req_oh : 16'd0);
    count_nxt    = count_q + {4'd0, iss_ok} - {4'd0, ack_hit};
    err_nxt      = err_q | ack_bad | iss_dup;
    err_code_nxt = err_code_q;
    if (!err_q) begin
      if (ack_bad)      err_code_nxt = 2'd2;
      else if (iss_dup) err_code_nxt = 2'd1;
    end
    rd_done_nxt  = ack_hit & ~ack_we_i;
    wr_done_nxt  = ack_hit &  ack_we_i;
    done_id_nxt  = ack_hit ? ack_id : done_id_q;
    if (clr_i) begin
      rd_pend_nxt  = '0;
      wr_pend_nxt  = '0;
      count_nxt    = '0;
      err_nxt      = 1'b0;
      err_code_nxt = 2'd0;
      rd_done_nxt  = 1'b0;
      wr_done_nxt  = 1'b0;
      done_id_nxt  = 4'd0;
    end
  end

  // FSM next state: IDLE -> BUSY on issue, BUSY -> IDLE when drained,
  // BUSY -> TIMEOUT on watchdog expiry, only clr_i leaves TIMEOUT.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:    if (iss_ok) state_nxt = ST_BUSY;
      ST_BUSY: begin
        if (count_nxt == 5'd0) state_nxt = ST_IDLE;
        else if (wd_fire)      state_nxt = ST_TIMEOUT;
      end
      ST_TIMEOUT: state_nxt = ST_TIMEOUT;
      default:    state_nxt = ST_IDLE;
    endcase
    if (clr_i) state_nxt = ST_IDLE;
  end

  // State register for the FSM and tracking datapath; ce_i freezes all of it.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      rd_pend_q  <= '0;
      wr_pend_q  <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'd0;
      rd_done_q  <= 1'b0;
      wr_done_q  <= 1'b0;
      done_id_q  <= 4'd0;
    end else if (ce_i) begin
      state_q    <= state_nxt;
      rd_pend_q  <= rd_pend_nxt;
      wr_pend_q  <= wr_pend_nxt;
      count_q    <= count_nxt;
      err_q      <= err_nxt;
      err_code_q <= err_code_nxt;
      rd_done_q  <= rd_done_nxt;
      wr_done_q  <= wr_done_nxt;
      done_id_q  <= done_id_nxt;
    end
  end

`ifdef ACK_TRACKER_WATCHDOG_EN
  localparam logic [15:0] TMO_LIM = 16'(TIMEOUT);

  logic [15:0] wd_q, wd_nxt;
  logic        tmo_nxt;

  // Watchdog fires on the edge where the count would reach TIMEOUT, so tmo_o
  // rises exactly TIMEOUT edges after BUSY is entered; it never wraps.
  always_comb begin
    wd_fire = (state_q == ST_BUSY) & ~ack_vld & ((wd_q + 16'd1) == TMO_LIM);
    wd_nxt  = wd_q;
    if (clr_i || state_q == ST_IDLE || ack_vld) wd_nxt = 16'd0;
    else if (state_q == ST_BUSY)                wd_nxt = wd_q + 16'd1;
    tmo_nxt = clr_i ? 1'b0 : (tmo_q | wd_fire);
  end

  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wd_q  <= 16'd0;
      tmo_q <= 1'b0;
    end else if (ce_i) begin
      wd_q  <= wd_nxt;
      tmo_q <= tmo_nxt;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_fire        = 1'b0;
  assign tmo_q          = 1'b0;
`endif

endmodule

// File: tb/tb_ack_tracker.sv
// Directed bench for ack_tracker (MAX_OUT=8, TIMEOUT=10, ACK_LEVEL=0).
module tb_ack_tracker;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic       ce_i, req_i, req_we_i, ack_i, ack_we_i, clr_i;
  logic [3:0] req_id_i, ack_rid_i, ack_wid_i;
  logic       req_rdy_o, busy_o, rd_done_o, wr_done_o, err_o, tmo_o;
  logic [3:0] done_id_o;
  logic [1:0] err_code_o, state_o;
  logic [4:0] count_o;

  int total = 0;
  int bad   = 0;

  ack_tracker #(.MAX_OUT(8), .TIMEOUT(10), .ACK_LEVEL(1'b0)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ce_i(ce_i), .req_i(req_i),
    .req_we_i(req_we_i), .req_id_i(req_id_i), .ack_i(ack_i),
    .ack_we_i(ack_we_i), .ack_rid_i(ack_rid_i), .ack_wid_i(ack_wid_i),
    .clr_i(clr_i), .req_rdy_o(req_rdy_o), .busy_o(busy_o),
    .rd_done_o(rd_done_o), .wr_done_o(wr_done_o), .done_id_o(done_id_o),
    .err_o(err_o), .err_code_o(err_code_o), .tmo_o(tmo_o),
    .count_o(count_o), .state_o(state_o)
  );

  // clock / reset
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // driver tasks
  task automatic idle_inputs();
    ce_i = 1'b1; req_i = 1'b0; req_we_i = 1'b0; req_id_i = 4'd0;
    ack_i = 1'b0; ack_we_i = 1'b0; ack_rid_i = 4'd0; ack_wid_i = 4'd0;
    clr_i = 1'b0;
  endtask

  task automatic drive_issue(input logic we, input logic [3:0] id);
    req_i = 1'b1; req_we_i = we; req_id_i = id;
  endtask

  task automatic drive_ack(input logic we, input logic [3:0] id);
    ack_i = 1'b1; ack_we_i = we;
    if (we) ack_wid_i = id; else ack_rid_i = id;
  endtask

  task automatic do_clear();
    idle_inputs(); clr_i = 1'b1; tick(); clr_i = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_ni = 1'b0;
    tick(); tick();
    total++; if (count_o !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    total++; if (req_rdy_o !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", req_rdy_o); end
    total++; if ({busy_o, err_o, err_code_o, tmo_o, rd_done_o, wr_done_o} !== 7'd0) begin
      bad++; $display("FAIL reset_flags got=%b exp=0", {busy_o, err_o, err_code_o, tmo_o, rd_done_o, wr_done_o}); end
    total++; if (state_o !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", state_o); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_single_read();
    drive_issue(1'b0, 4'd3); tick(); idle_inputs();
    total++; if (count_o !== 5'd1 || busy_o !== 1'b1 || state_o !== 2'd1) begin
      bad++; $display("FAIL rd_issue count=%0d busy=%b state=%0d exp 1/1/1", count_o, busy_o, state_o); end
    tick();
    drive_ack(1'b0, 4'd3);
    total++; if (rd_done_o !== 1'b0) begin bad++; $display("FAIL rd_done_early got=%b exp=0", rd_done_o); end
    tick(); idle_inputs();
    total++; if (rd_done_o !== 1'b1 || done_id_o !== 4'd3 || wr_done_o !== 1'b0) begin
      bad++; $display("FAIL rd_done rd=%b wr=%b id=%0d exp 1/0/3", rd_done_o, wr_done_o, done_id_o); end
    total++; if (count_o !== 5'd0 || busy_o !== 1'b0 || state_o !== 2'd0) begin
      bad++; $display("FAIL rd_drain count=%0d busy=%b state=%0d exp 0/0/0", count_o, busy_o, state_o); end
    tick();
    total++; if (rd_done_o !== 1'b0) begin bad++; $display("FAIL rd_done_width got=%b exp=0", rd_done_o); end
  endtask

  task automatic test_max_out();
    for (int i = 0; i < 8; i++) begin
      drive_issue(1'b1, 4'(i)); tick();
    end
    idle_inputs();
    total++; if (count_o !== 5'd8 || req_rdy_o !== 1'b0) begin
      bad++; $display("FAIL max_full count=%0d rdy=%b exp 8/0", count_o, req_rdy_o); end
    drive_issue(1'b1, 4'd8); tick(); idle_inputs();
    total++; if (count_o !== 5'd8 || err_o !== 1'b0) begin
      bad++; $display("FAIL max_ignore count=%0d err=%b exp 8/0", count_o, err_o); end
    for (int i = 0; i < 8; i++) begin
      drive_ack(1'b1, 4'(i)); tick();
      total++; if (wr_done_o !== 1'b1 || done_id_o !== 4'(i) || count_o !== 5'(7 - i)) begin
        bad++; $display("FAIL wr_ack%0d done=%b id=%0d count=%0d exp 1/%0d/%0d", i, wr_done_o, done_id_o, count_o, i, 7 - i); end
    end
    idle_inputs(); tick();
    total++; if (state_o !== 2'd0 || err_o !== 1'b0) begin
      bad++; $display("FAIL max_end state=%0d err=%b exp 0/0", state_o, err_o); end
  endtask

  task automatic test_errors();
    drive_ack(1'b1, 4'd5); tick(); idle_inputs();
    total++; if (err_o !== 1'b1 || err_code_o !== 2'd2 || wr_done_o !== 1'b0) begin
      bad++; $display("FAIL bad_ack err=%b code=%0d wr_done=%b exp 1/2/0", err_o, err_code_o, wr_done_o); end
    total++; if (req_rdy_o !== 1'b0) begin bad++; $display("FAIL err_rdy got=%b exp=0", req_rdy_o); end
    drive_issue(1'b0, 4'd2); tick(); drive_issue(1'b0, 4'd2); tick(); idle_inputs();
    total++; if (err_code_o !== 2'd2 || count_o !== 5'd0) begin
      bad++; $display("FAIL err_hold code=%0d count=%0d exp 2/0", err_code_o, count_o); end
    do_clear(); tick();
    total++; if (err_o !== 1'b0 || err_code_o !== 2'd0) begin
      bad++; $display("FAIL err_clr err=%b code=%0d exp 0/0", err_o, err_code_o); end
    drive_issue(1'b0, 4'd6); tick(); tick(); idle_inputs();
    total++; if (err_o !== 1'b1 || err_code_o !== 2'd1 || count_o !== 5'd1) begin
      bad++; $display("FAIL dup_issue err=%b code=%0d count=%0d exp 1/1/1", err_o, err_code_o, count_o); end
    drive_ack(1'b1, 4'd6); tick(); idle_inputs();
    total++; if (err_code_o !== 2'd1 || count_o !== 5'd1) begin
      bad++; $display("FAIL first_cause code=%0d count=%0d exp 1/1", err_code_o, count_o); end
    do_clear(); tick();
    total++; if (count_o !== 5'd0 || err_o !== 1'b0 || state_o !== 2'd0) begin
      bad++; $display("FAIL clr_all count=%0d err=%b state=%0d exp 0/0/0", count_o, err_o, state_o); end
  endtask

  task automatic test_back_to_back();
    drive_issue(1'b0, 4'd4); tick();
    drive_ack(1'b0, 4'd4); tick(); idle_inputs();
    total++; if (rd_done_o !== 1'b1 || done_id_o !== 4'd4 || count_o !== 5'd1 || err_o !== 1'b0) begin
      bad++; $display("FAIL same_id done=%b id=%0d count=%0d err=%b exp 1/4/1/0", rd_done_o, done_id_o, count_o, err_o); end
    drive_ack(1'b0, 4'd4); tick(); idle_inputs();
    total++; if (count_o !== 5'd0 || err_o !== 1'b0 || rd_done_o !== 1'b1) begin
      bad++; $display("FAIL same_id_kept count=%0d err=%b done=%b exp 0/0/1", count_o, err_o, rd_done_o); end
    drive_issue(1'b0, 4'd1); tick();
    drive_issue(1'b0, 4'd2); drive_ack(1'b0, 4'd1); tick(); idle_inputs();
    total++; if (count_o !== 5'd1 || done_id_o !== 4'd1 || err_o !== 1'b0) begin
      bad++; $display("FAIL diff_id count=%0d id=%0d err=%b exp 1/1/0", count_o, done_id_o, err_o); end
    drive_ack(1'b0, 4'd2); tick(); idle_inputs();
    total++; if (count_o !== 5'd0 || done_id_o !== 4'd2 || err_o !== 1'b0) begin
      bad++; $display("FAIL diff_id_drain count=%0d id=%0d err=%b exp 0/2/0", count_o, done_id_o, err_o); end
  endtask

  task automatic test_ce();
    ce_i = 1'b0; drive_issue(1'b1, 4'd9); tick(); tick(); idle_inputs();
    total++; if (count_o !== 5'd0 || state_o !== 2'd0) begin
      bad++; $display("FAIL ce_freeze count=%0d state=%0d exp 0/0", count_o, state_o); end
  endtask

  task automatic test_watchdog();
    drive_issue(1'b0, 4'd0); tick(); idle_inputs();
`ifdef ACK_TRACKER_WATCHDOG_EN
    for (int i = 0; i < 9; i++) tick();
    total++; if (tmo_o !== 1'b0) begin bad++; $display("FAIL tmo_early got=%b exp=0", tmo_o); end
    tick();
    total++; if (tmo_o !== 1'b1 || state_o !== 2'd2 || req_rdy_o !== 1'b0) begin
      bad++; $display("FAIL tmo_fire tmo=%b state=%0d rdy=%b exp 1/2/0", tmo_o, state_o, req_rdy_o); end
    do_clear(); tick();
    total++; if (tmo_o !== 1'b0 || state_o !== 2'd0 || count_o !== 5'd0 || busy_o !== 1'b0) begin
      bad++; $display("FAIL tmo_clr tmo=%b state=%0d count=%0d exp 0/0/0", tmo_o, state_o, count_o); end
`else
    for (int i = 0; i < 20; i++) tick();
    total++; if (tmo_o !== 1'b0 || state_o !== 2'd1) begin
      bad++; $display("FAIL no_wd tmo=%b state=%0d exp 0/1", tmo_o, state_o); end
    drive_ack(1'b0, 4'd0); tick(); idle_inputs();
    total++; if (count_o !== 5'd0 || state_o !== 2'd0) begin
      bad++; $display("FAIL no_wd_drain count=%0d state=%0d exp 0/0", count_o, state_o); end
`endif
  endtask

  task automatic test_async_reset();
    drive_issue(1'b0, 4'd7); tick();
    drive_issue(1'b0, 4'd8); tick();
    drive_issue(1'b0, 4'd9); tick(); idle_inputs();
    total++; if (count_o !== 5'd3) begin bad++; $display("FAIL pre_rst count=%0d exp=3", count_o); end
    #2 rst_ni = 1'b0;
    #1;
    total++; if (count_o !== 5'd0 || busy_o !== 1'b0 || state_o !== 2'd0) begin
      bad++; $display("FAIL async_rst count=%0d busy=%b state=%0d exp 0/0/0", count_o, busy_o, state_o); end
    tick();
    rst_ni = 1'b1;
    drive_ack(1'b0, 4'd7); tick(); idle_inputs();
    total++; if (err_o !== 1'b1 || err_code_o !== 2'd2 || rd_done_o !== 1'b0) begin
      bad++; $display("FAIL post_rst_ack err=%b code=%0d done=%b exp 1/2/0", err_o, err_code_o, rd_done_o); end
    do_clear();
  endtask

  // sequence and final report
  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_max_out();
    test_errors();
    test_back_to_back();
    test_ce();
    test_watchdog();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
